cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  Sequences the 2-way, 64-bit-line data cache between the MEM stage and word-wide SRAM.
//  Serves read hits in the same cycle. On a read miss it fetches two words from SRAM and fills the line.
//  Writes go through to SRAM and invalidate any matching cache line.
//  Sits between the MEM stage and the SRAM controller; stalls the pipeline via ready.
// PARAMETERS
//  BASE_ADDR  1024  byte address mapped to cache/SRAM offset 0
// PORTS
//  clk               in   1   system clock, rising edge
//  rst               in   1   synchronous reset, active-high
//  mem_r_en          in   1   CPU read request, held until ready
//  mem_w_en          in   1   CPU write request, held until ready
//  address           in   32  CPU byte address
//  wdata             in   32  CPU write data
//  rdata             out  32  CPU read data, valid when ready & mem_r_en
//  ready             out  1   request complete this cycle (combinational)
//  cache_address     out  19  (address-BASE_ADDR)[18:0]; {tag10,index6,offset3}
//  cache_read        out  1   LRU-update strobe on read hit
//  cache_write       out  1   line-fill strobe
//  mem_write         out  1   invalidate strobe on write
//  cache_write_data  out  64  fill line {hi_word, lo_word}
//  hit               in   1   cache hit for cache_address
//  cache_read_data   in   32  cache word for cache_address
//  sram_r_en         out  1   SRAM read request, held until sram_ready
//  sram_w_en         out  1   SRAM write request, held until sram_ready
//  sram_address      out  32  SRAM byte address
//  sram_wdata        out  32  SRAM write data (= wdata)
//  sram_rdata        in   32  SRAM read data, valid with sram_ready
//  sram_ready        in   1   SRAM access done this cycle (single-cycle pulse)
// BEHAVIOUR
//  - Reset: state=IDLE; lo_buf=0, hi_buf=0; every strobe output=0 and ready=0 while rst=1.
//  - States: IDLE, RD_LO, RD_HI, FILL, WR.
//  - Line base A0 = address & ~32'h7. lo word at A0, hi word at A0+4. Word select = cache_address[2].
//  - IDLE, mem_w_en=1: this has priority over mem_r_en.
//    * Assert mem_write for 1 cycle; go to WR.
//    * The cache drops the line only if hit.
//  - IDLE, mem_r_en=1 & hit=1: cache_read=1, ready=1, rdata=cache_read_data in the same cycle. Stay in IDLE.
//  - IDLE, mem_r_en=1 & hit=0: go to RD_LO.
//  - RD_LO: sram_r_en=1, sram_address=A0. On sram_ready: lo_buf<=sram_rdata, go to RD_HI.
//  - RD_HI: sram_r_en=1, sram_address=A0+4. On sram_ready: hi_buf<=sram_rdata, go to FILL.
//  - FILL (1 cycle):
//    * cache_write=1, cache_write_data={hi_buf,lo_buf}.
//    * ready=1, rdata = cache_address[2] ? hi_buf : lo_buf.
//    * Go to IDLE.
//  - WR: sram_w_en=1, sram_address=address. On sram_ready: ready=1, go to IDLE.
//  - Latency:
//    * Read hit: 0 wait cycles.
//    * Read miss: 1 + tLO + tHI cycles (tLO/tHI = cycles until each sram_ready), then the FILL cycle.
//    * Write: 1 + tWR cycles.
//  - sram_r_en and sram_w_en are never both 1. The next request is accepted no earlier than the cycle after ready.
//  - Outside the states listed above: rdata=0 and cache_write_data=0.
//  - Request dropped mid-operation (protocol violation): the sequence still completes; no recovery is required.
//  - rst=1 mid-miss or mid-write: next state IDLE, all strobes drop at once, buffers cleared.
//    Cache contents are left untouched; a partial fill is never written.
//  - Subtraction is 32-bit with wrap. Addresses below BASE_ADDR are not checked.
// TESTING
//  - Read miss at 1028, SRAM[1024]=A, SRAM[1028]=B, 2-cycle SRAM:
//    sram_address 1024 then 1028; cache_write with data {B,A}; ready with rdata=B.
//  - Repeat the read at 1028: hit=1, ready in the same cycle, rdata=cache_read_data, cache_read=1, no sram_r_en.
//  - Write 1028 with data 5 while hit: mem_write pulses exactly 1 cycle; sram_w_en until sram_ready; ready=1.
//    A following read of 1028 misses and refetches.
//  - mem_r_en and mem_w_en both 1 in IDLE: the write path is taken and sram_r_en stays 0.
//  - rst=1 in RD_HI: next cycle IDLE, sram_r_en=0, cache_write never asserted.
//  - sram_ready stuck at 0: FSM waits in RD_LO with ready=0 indefinitely.

Source files
------------

// File: rtl/cache_controller.sv
// Cache controller: sequences a 2-way, 64-bit-line data cache between the MEM stage and word-wide SRAM.
// Read hits complete in the same cycle; misses fetch two words and fill the line; writes go through and invalidate.
module cache_controller #(
    parameter logic [31:0] BASE_ADDR = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [18:0] cache_address,
    output logic        cache_read,
    output logic        cache_write,
    output logic        mem_write,
    output logic [63:0] cache_write_data,
    input  logic        hit,
    input  logic [31:0] cache_read_data,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready,
    output logic [2:0]  dbg_state_o
);
    // Handshake: a CPU request (mem_r_en / mem_w_en) is held until ready, which marks completion in that
    // cycle; an SRAM request (sram_r_en / sram_w_en) is held until the single-cycle sram_ready pulse.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD_LO = 3'd1;
    localparam logic [2:0] RD_HI = 3'd2;
    localparam logic [2:0] FILL  = 3'd3;
    localparam logic [2:0] WR    = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] line_base;

    // Only the low 19 bits of the wrapped 32-bit offset are used, so a 19-bit subtraction is equivalent.
    assign cache_address = address[18:0] - BASE_ADDR[18:0];
    assign line_base     = {address[31:3], 3'b000};
    assign sram_wdata    = wdata;
    assign dbg_state_o   = state_q;

    always_comb begin
        state_d          = state_q;
        lo_d             = lo_q;
        hi_d             = hi_q;
        rdata            = 32'd0;
        ready            = 1'b0;
        cache_read       = 1'b0;
        cache_write      = 1'b0;
        mem_write        = 1'b0;
        cache_write_data = 64'd0;
        sram_r_en        = 1'b0;
        sram_w_en        = 1'b0;
        sram_address     = 32'd0;
        case (state_q)
            IDLE: begin
                if (mem_w_en) begin
                    mem_write = 1'b1;
                    state_d   = WR;
                end else if (mem_r_en) begin
                    if (hit) begin
                        cache_read = 1'b1;
                        ready      = 1'b1;
                        rdata      = cache_read_data;
                    end else begin
                        state_d = RD_LO;
                    end
                end
            end
            RD_LO: begin
                sram_r_en    = 1'b1;
                sram_address = line_base;
                if (sram_ready) begin
                    lo_d    = sram_rdata;
                    state_d = RD_HI;
                end
            end
            RD_HI: begin
                sram_r_en    = 1'b1;
                sram_address = line_base + 32'd4;
                if (sram_ready) begin
                    hi_d    = sram_rdata;
                    state_d = FILL;
                end
            end
            FILL: begin
                cache_write      = 1'b1;
                cache_write_data = {hi_q, lo_q};
                ready            = 1'b1;
                rdata            = cache_address[2] ? hi_q : lo_q;
                state_d          = IDLE;
            end
            WR: begin
                sram_w_en    = 1'b1;
                sram_address = address;
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset silences every strobe immediately so a partial fill can never reach the cache.
        if (rst) begin
            rdata            = 32'd0;
            ready            = 1'b0;
            cache_read       = 1'b0;
            cache_write      = 1'b0;
            mem_write        = 1'b0;
            cache_write_data = 64'd0;
            sram_r_en        = 1'b0;
            sram_w_en        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed vector table, hand-written reset/stall sequences, and random
// transactions checked against a transaction-level model of memory and line residency.
module tb_cache_controller;
    localparam int         BUDGET  = 200;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RDLO = 3'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, wdata, rdata;
    logic        ready;
    logic [18:0] cache_address;
    logic        cache_read, cache_write, mem_write;
    logic [63:0] cache_write_data;
    logic        hit;
    logic [31:0] cache_read_data;
    logic        sram_r_en, sram_w_en;
    logic [31:0] sram_address, sram_wdata;
    logic [31:0] sram_rdata = 32'd0;
    logic        sram_ready = 1'b0;
    logic [2:0]  dbg_state;

    cache_controller #(.BASE_ADDR(32'd1024)) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
        .cache_address(cache_address), .cache_read(cache_read), .cache_write(cache_write),
        .mem_write(mem_write), .cache_write_data(cache_write_data), .hit(hit),
        .cache_read_data(cache_read_data), .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
        .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ready(sram_ready), .dbg_state_o(dbg_state)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction
    function automatic int widx(input logic [31:0] a);
        return int'((a - 32'd1024) >> 2) & 511;
    endfunction
    function automatic int lidx(input logic [31:0] a);
        return int'((a - 32'd1024) >> 3) & 255;
    endfunction

    // Cache array stand-in (unbounded associativity over the tested address range).
    logic        cvalid [256] = '{default: 1'b0};
    logic [63:0] cdata  [256] = '{default: 64'h0};
    logic [7:0]  cidx;
    assign cidx            = cache_address[10:3];
    assign hit             = cvalid[cidx];
    assign cache_read_data = cache_address[2] ? cdata[cidx][63:32] : cdata[cidx][31:0];
    always @(posedge clk) begin
        if (cache_write) begin
            cvalid[cidx] <= 1'b1;
            cdata[cidx]  <= cache_write_data;
        end
        if (mem_write && hit) cvalid[cidx] <= 1'b0;
    end

    // SRAM stand-in: pulses sram_ready on the sram_lat-th cycle of a held request.
    logic [31:0] sram_mem [512];
    int sram_lat   = 1;
    bit sram_stuck = 1'b0;
    int sram_cnt   = 0;
    bit mem_init   = 1'b0;
    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 512; i++) sram_mem[i] = pat(32'd1024 + 32'(4 * i));
            mem_init = 1'b1;
        end
        if (sram_ready) begin
            sram_ready = 1'b0;
            sram_cnt   = 0;
        end
        if (sram_r_en || sram_w_en) begin
            sram_cnt++;
            if (!sram_stuck && sram_cnt == sram_lat) begin
                sram_ready = 1'b1;
                sram_rdata = sram_mem[widx(sram_address)];
                if (sram_w_en) sram_mem[widx(sram_address)] = sram_wdata;
            end
        end else begin
            sram_cnt = 0;
        end
    end

    // Reference model: word contents and which lines are resident.
    logic [31:0] ref_mem [512];
    bit          ref_valid [256];
    logic [31:0] exp_q [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-transaction observations.
    int          mon_cyc, mon_mw, mon_cw, mon_cr, mon_sr, mon_both;
    bit          mon_done;
    logic [31:0] mon_rdata;
    logic [63:0] mon_cw_data;
    logic [31:0] mon_addr [$];

    function automatic logic [31:0] q_word(input int i);
        return (mon_addr.size() > i) ? mon_addr[i] : 32'hFFFF_FFFF;
    endfunction

    // Call at a falling edge; returns at a falling edge with the request dropped.
    task automatic do_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd, input int lat);
        sram_lat = lat;
        mon_cyc = -1; mon_mw = 0; mon_cw = 0; mon_cr = 0; mon_sr = 0; mon_both = 0;
        mon_done = 1'b0; mon_rdata = 32'd0; mon_cw_data = 64'd0;
        mon_addr.delete();
        mem_w_en = wr; mem_r_en = rd; address = a; wdata = wd;
        for (int c = 0; c < BUDGET; c++) begin
            #1;
            if (mem_write)   mon_mw++;
            if (cache_write) begin mon_cw++; mon_cw_data = cache_write_data; end
            if (cache_read)  mon_cr++;
            if (sram_r_en)   mon_sr++;
            if (sram_r_en && sram_w_en) mon_both++;
            if (sram_ready)  mon_addr.push_back(sram_address);
            if (ready) begin
                mon_rdata = rdata;
                mon_cyc   = c;
                mon_done  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        mem_w_en = 1'b0;
        mem_r_en = 1'b0;
    endtask

    task automatic run_txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] wd, input int lat);
        logic [31:0] a0;
        bit          exp_hit;
        logic [63:0] exp_fill;
        int          exp_cyc;
        a0       = {a[31:3], 3'b000};
        exp_hit  = ref_valid[lidx(a)];
        exp_fill = {ref_mem[widx(a0 + 32'd4)], ref_mem[widx(a0)]};
        if (wr)           exp_cyc = lat;
        else if (exp_hit) exp_cyc = 0;
        else              exp_cyc = 1 + 2 * lat;
        if (!wr) exp_q.push_back(ref_mem[widx(a)]);
        do_req(wr, rd, a, wd, lat);
        if (!mon_done) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: no ready within %0d cycles at addr %h", BUDGET, a);
            if (!wr) void'(exp_q.pop_front());
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            return;
        end
        check("cycles", 64'(mon_cyc), 64'(exp_cyc));
        check("sram_exclusive", 64'(mon_both), 64'd0);
        if (wr) begin
            check("mem_write_pulses", 64'(mon_mw), 64'd1);
            check("wr_no_sram_read", 64'(mon_sr), 64'd0);
            check("wr_sram_addr", q_word(0), a);
            check("wr_sram_data", sram_mem[widx(a)], wd);
            ref_mem[widx(a)]   = wd;
            ref_valid[lidx(a)] = 1'b0;
        end else begin
            check("rdata", mon_rdata, exp_q.pop_front());
            if (exp_hit) begin
                check("hit_cache_read", 64'(mon_cr), 64'd1);
                check("hit_no_sram", 64'(mon_sr), 64'd0);
            end else begin
                check("miss_sram_addrs", {q_word(0), q_word(1)}, {a0, a0 + 32'd4});
                check("fill_data", mon_cw_data, exp_fill);
                check("fill_strobes", 64'(mon_cw), 64'd1);
            end
            ref_valid[lidx(a)] = 1'b1;
        end
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        logic [31:0] exp_rdata;
        int          exp_cyc;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bit          found, stuck_ok, saw_ready;
        int          cw;

        vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'd0,          2, 32'hC0DE_0404, 5};
        vecs[1] = '{1'b0, 1'b1, 32'd1028, 32'd0,          2, 32'hC0DE_0404, 0};
        vecs[2] = '{1'b0, 1'b1, 32'd1024, 32'd0,          2, 32'hC0DE_0400, 0};
        vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'd5,          2, 32'd0,         2};
        vecs[4] = '{1'b0, 1'b1, 32'd1028, 32'd0,          1, 32'd5,         3};
        vecs[5] = '{1'b0, 1'b1, 32'd2060, 32'd0,          3, 32'hC0DE_080C, 7};
        vecs[6] = '{1'b1, 1'b1, 32'd2060, 32'hDEAD_BEEF,  1, 32'd0,         1};
        vecs[7] = '{1'b0, 1'b1, 32'd2056, 32'd0,          1, 32'hC0DE_0808, 3};
        vecs[8] = '{1'b0, 1'b1, 32'd2060, 32'd0,          2, 32'hDEAD_BEEF, 0};

        for (int i = 0; i < 512; i++) ref_mem[i] = pat(32'd1024 + 32'(4 * i));

        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; address = 32'd1024; wdata = 32'd0;
        repeat (2) @(negedge clk);
        mem_r_en = 1'b1;
        #1;
        check("reset_outputs", {58'd0, ready, cache_read, cache_write, mem_write, sram_r_en, sram_w_en}, 64'd0);
        @(negedge clk);
        rst = 1'b0; mem_r_en = 1'b0;
        #1;
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);

        foreach (vecs[i]) begin
            run_txn(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].lat);
            check("tbl_cycles", 64'(mon_cyc), 64'(vecs[i].exp_cyc));
            if (vecs[i].rd && !vecs[i].wr) check("tbl_rdata", mon_rdata, vecs[i].exp_rdata);
        end

        // Reset while the high word is outstanding: no fill, back to IDLE.
        a = 32'd2624; cw = 0; found = 1'b0;
        sram_lat = 3; mem_r_en = 1'b1; address = a;
        for (int c = 0; c < BUDGET; c++) begin
            #1;
            if (cache_write) cw++;
            if (sram_r_en && sram_address == a + 32'd4) begin found = 1'b1; break; end
            @(negedge clk);
        end
        check("reached_rd_hi", 64'(found), 64'd1);
        @(negedge clk);
        rst = 1'b1; mem_r_en = 1'b0;
        #1;
        if (cache_write) cw++;
        check("rst_strobes_low", {58'd0, ready, cache_write, sram_r_en, sram_w_en, mem_write, cache_read}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_no_sram_r", 64'(sram_r_en), 64'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            if (cache_write) cw++;
        end
        check("no_partial_fill", 64'(cw), 64'd0);
        check("line_not_filled", 64'(cvalid[lidx(a)]), 64'd0);

        // SRAM never answers: controller parks in RD_LO without ready.
        @(negedge clk);
        a = 32'd2632; sram_stuck = 1'b1; stuck_ok = 1'b1; saw_ready = 1'b0;
        mem_r_en = 1'b1; address = a;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (ready) saw_ready = 1'b1;
            if (c >= 1 && !(sram_r_en && sram_address == a)) stuck_ok = 1'b0;
            @(negedge clk);
        end
        #1;
        check("stuck_no_ready", 64'(saw_ready), 64'd0);
        check("stuck_holds_req", 64'(stuck_ok), 64'd1);
        check("stuck_state", 64'(dbg_state), 64'(ST_RDLO));
        @(negedge clk);
        rst = 1'b1; mem_r_en = 1'b0; sram_stuck = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] ra;
            bit          rw, rr;
            ra = 32'd1024 + 32'(4 * $urandom_range(0, 63));
            rw = ($urandom_range(0, 3) == 0);
            rr = rw ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(rw, rr, ra, $urandom, $urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
